// File: rtl/flash_sample_fetcher_pkg.sv
// Shared widths, FSM states and Avalon tie-off values for the flash sample fetcher.
// Pure declarations, no logic.
package flash_fetch_pkg;

  localparam int FLASH_AW = 23;
  localparam int FLASH_DW = 32;
  localparam int SAMPLE_W = 16;

  localparam logic [6:0]          FLASH_BURSTCOUNT = 7'd1;
  localparam logic                FLASH_WRITE      = 1'b0;
  localparam logic [3:0]          FLASH_BYTEENABLE = 4'hF;
  localparam logic [FLASH_DW-1:0] FLASH_WRITEDATA  = '0;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_DATA,
    WR_LO,
    WR_HI,
    DONE
  } state_t;

endpackage

// File: rtl/flash_sample_fetcher_if.sv
// Flash Avalon-MM read port plus sample RAM write port of the fetcher.
// master = fetcher side, slave = flash controller / RAM side.
interface flash_sample_fetcher_if #(
  parameter int RAM_AW = 8
);
  import flash_fetch_pkg::*;

  logic                flash_mem_read;
  logic [FLASH_AW-1:0] flash_mem_address;
  logic                flash_mem_waitrequest;
  logic [FLASH_DW-1:0] flash_mem_readdata;
  logic                flash_mem_readdatavalid;
  logic [6:0]          flash_mem_burstcount;
  logic                flash_mem_write;
  logic [3:0]          flash_mem_byteenable;
  logic [FLASH_DW-1:0] flash_mem_writedata;

  logic                ram_wren;
  logic [RAM_AW-1:0]   ram_addr;
  logic [SAMPLE_W-1:0] ram_wrdata;

  modport master (
    output flash_mem_read, flash_mem_address, flash_mem_burstcount,
           flash_mem_write, flash_mem_byteenable, flash_mem_writedata,
           ram_wren, ram_addr, ram_wrdata,
    input  flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid
  );

  modport slave (
    input  flash_mem_read, flash_mem_address, flash_mem_burstcount,
           flash_mem_write, flash_mem_byteenable, flash_mem_writedata,
           ram_wren, ram_addr, ram_wrdata,
    output flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid
  );

endinterface

// File: rtl/flash_sample_fetcher.sv
// Reads NUM_WORDS flash words (one outstanding read) and writes each as two 16-bit samples, low first.
// 4 cycles/word with no stalls; waitrequest holds the request, readdatavalid timing stretches WAIT_DATA.
module flash_sample_fetcher
  import flash_fetch_pkg::*;
#(
  parameter int                  NUM_WORDS = 128,
  parameter logic [FLASH_AW-1:0] BASE_ADDR = '0,
  parameter int                  RAM_AW    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     done,
  flash_sample_fetcher_if.master   bus
);

  localparam int               CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    word_cnt, word_cnt_nxt;
  logic [SAMPLE_W-1:0] hold_hi;
  logic [RAM_AW-1:0]   lo_idx;
  logic [RAM_AW-1:0]   hi_idx;

  assign bus.flash_mem_burstcount = FLASH_BURSTCOUNT;
  assign bus.flash_mem_write      = FLASH_WRITE;
  assign bus.flash_mem_byteenable = FLASH_BYTEENABLE;
  assign bus.flash_mem_writedata  = FLASH_WRITEDATA;

  // Sample index wraps modulo the RAM size.
  assign lo_idx = RAM_AW'({word_cnt, 1'b0});
  assign hi_idx = lo_idx | RAM_AW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      word_cnt <= '0;
    end else begin
      state    <= state_nxt;
      word_cnt <= word_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    word_cnt_nxt = word_cnt;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt    = REQ;
          word_cnt_nxt = '0;
        end
      end
      REQ: begin
        if (!bus.flash_mem_waitrequest) state_nxt = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (bus.flash_mem_readdatavalid) state_nxt = WR_LO;
      end
      WR_LO: state_nxt = WR_HI;
      WR_HI: begin
        if (word_cnt == LAST_WORD) begin
          state_nxt = DONE;
        end else begin
          state_nxt    = REQ;
          word_cnt_nxt = word_cnt + 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          state_nxt    = REQ;
          word_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt    = IDLE;
        word_cnt_nxt = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.flash_mem_read    <= 1'b0;
      bus.flash_mem_address <= BASE_ADDR;
      bus.ram_wren          <= 1'b0;
      bus.ram_addr          <= '0;
      bus.ram_wrdata        <= '0;
      hold_hi               <= '0;
      done                  <= 1'b0;
    end else begin
      bus.flash_mem_read    <= (state_nxt == REQ);
      bus.flash_mem_address <= BASE_ADDR + FLASH_AW'(word_cnt_nxt);
      bus.ram_wren          <= (state_nxt == WR_LO) || (state_nxt == WR_HI);
      done                  <= (state_nxt == DONE);
      if (state == WAIT_DATA && bus.flash_mem_readdatavalid) begin
        hold_hi        <= bus.flash_mem_readdata[FLASH_DW-1:SAMPLE_W];
        bus.ram_addr   <= lo_idx;
        bus.ram_wrdata <= bus.flash_mem_readdata[SAMPLE_W-1:0];
      end else if (state == WR_LO) begin
        bus.ram_addr   <= hi_idx;
        bus.ram_wrdata <= hold_hi;
      end
    end
  end

endmodule

// File: tb/tb_flash_sample_fetcher.sv
// Directed bench: flash slave model with stalls/latency/spurious valid, RAM write scoreboard,
// async reset mid-run and restart checks.
module tb_flash_sample_fetcher;
  import flash_fetch_pkg::*;

  localparam int                  NW   = 2;
  localparam logic [FLASH_AW-1:0] BASE = 23'h10;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic done;

  flash_sample_fetcher_if #(.RAM_AW(8)) bus ();

  flash_sample_fetcher #(
    .NUM_WORDS(NW),
    .BASE_ADDR(BASE),
    .RAM_AW   (8)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .done (done),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  wr_t                 exp_wr_q[$];
  logic [FLASH_AW-1:0] exp_addr_q[$];
  logic [31:0]         rd_q[$];

  int          wait_left = 0;
  int          valid_delay = 1;
  int          accepts = 0;
  int          wr_count = 0;
  int          spur_fired = 0;
  bit          spur_arm = 0;
  bit          pend = 0;
  int          pend_cnt = 0;
  logic [31:0] pend_data = '0;
  bit          stalled = 0;
  logic [22:0] stall_addr = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input int k, input logic [31:0] w);
    wr_t e;
    rd_q.push_back(w);
    exp_addr_q.push_back(BASE + FLASH_AW'(k));
    e.addr = 8'(2 * k);
    e.data = w[15:0];
    exp_wr_q.push_back(e);
    e.addr = 8'(2 * k + 1);
    e.data = w[31:16];
    exp_wr_q.push_back(e);
  endtask

  // Flash slave: optional stall on the first request, fixed read latency, optional spurious valid in WR_HI.
  initial begin
    bus.flash_mem_waitrequest   = 1'b0;
    bus.flash_mem_readdata      = '0;
    bus.flash_mem_readdatavalid = 1'b0;
    forever begin
      @(negedge clk);
      bus.flash_mem_readdatavalid = 1'b0;
      if (stalled) begin
        check("stall_read_held", 32'(bus.flash_mem_read), 32'd1);
        check("stall_addr_held", 32'(bus.flash_mem_address), 32'(stall_addr));
        stalled = 0;
      end
      if (pend) begin
        if (pend_cnt <= 1) begin
          bus.flash_mem_readdatavalid = 1'b1;
          bus.flash_mem_readdata      = pend_data;
          pend = 0;
        end else begin
          pend_cnt--;
        end
      end else if (spur_arm && bus.ram_wren === 1'b1 && bus.ram_addr[0] === 1'b1) begin
        bus.flash_mem_readdatavalid = 1'b1;
        bus.flash_mem_readdata      = 32'hDEAD_BEEF;
        spur_arm = 0;
        spur_fired++;
      end
      bus.flash_mem_waitrequest = 1'b0;
      if (bus.flash_mem_read === 1'b1 && !rst) begin
        check("one_outstanding", 32'(pend), 32'd0);
        if (wait_left > 0) begin
          bus.flash_mem_waitrequest = 1'b1;
          wait_left--;
          stalled    = 1;
          stall_addr = bus.flash_mem_address;
        end else begin
          check("addr_expected", 32'(exp_addr_q.size() > 0), 32'd1);
          if (exp_addr_q.size() > 0)
            check("flash_addr", 32'(bus.flash_mem_address), 32'(exp_addr_q.pop_front()));
          pend      = 1;
          pend_cnt  = valid_delay;
          pend_data = (rd_q.size() > 0) ? rd_q.pop_front() : 32'hBAD0_BAD0;
          accepts++;
        end
      end
    end
  end

  // RAM write scoreboard.
  always @(negedge clk) begin
    wr_t e;
    if (bus.ram_wren === 1'b1) begin
      wr_count++;
      check("ram_write_expected", 32'(exp_wr_q.size() > 0), 32'd1);
      if (exp_wr_q.size() > 0) begin
        e = exp_wr_q.pop_front();
        check("ram_addr", 32'(bus.ram_addr), 32'(e.addr));
        check("ram_wrdata", 32'(bus.ram_wrdata), 32'(e.data));
      end
    end
  end

  task automatic do_run(input string tag, input logic [31:0] w0, input logic [31:0] w1,
                        input int wait_n, input int delay, input int pulse_at, input int exp_edges);
    int edges;
    push_word(0, w0);
    push_word(1, w1);
    wait_left   = wait_n;
    valid_delay = delay;
    wr_count    = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    edges = 0;
    check({tag, "_done_low_after_start"}, 32'(done), 32'd0);
    while (done !== 1'b1 && edges < 500) begin
      @(negedge clk);
      edges++;
      start = (edges == pulse_at);
    end
    start = 1'b0;
    check({tag, "_done_edges"}, 32'(edges), 32'(exp_edges));
    repeat (3) @(negedge clk);
    check({tag, "_done_held"}, 32'(done), 32'd1);
    check({tag, "_write_count"}, 32'(wr_count), 32'(2 * NW));
    check({tag, "_wr_left"}, 32'(exp_wr_q.size()), 32'd0);
    check({tag, "_addr_left"}, 32'(exp_addr_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_read"}, 32'(bus.flash_mem_read), 32'd0);
    check({tag, "_address"}, 32'(bus.flash_mem_address), 32'(BASE));
    check({tag, "_wren"}, 32'(bus.ram_wren), 32'd0);
    check({tag, "_ram_addr"}, 32'(bus.ram_addr), 32'd0);
    check({tag, "_wrdata"}, 32'(bus.ram_wrdata), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int base_acc;
    int guard;
    #1 rst = 1'b1;
    #1;
    check_reset_outputs("por");
    check("burstcount", 32'(bus.flash_mem_burstcount), 32'd1);
    check("write", 32'(bus.flash_mem_write), 32'd0);
    check("byteenable", 32'(bus.flash_mem_byteenable), 32'hF);
    check("writedata", bus.flash_mem_writedata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic run: no stalls, data one cycle after acceptance.
    do_run("basic", 32'h0002_0001, 32'h0004_0003, 0, 1, -1, 8);
    // Restart from DONE with a 3-cycle stall on the first request.
    do_run("stall", 32'hA5A5_1234, 32'h0F0F_F0F0, 3, 1, -1, 11);
    // Long latency, spurious valid during WR_HI, start pulse while busy.
    spur_arm = 1;
    do_run("late", 32'h1357_2468, 32'hCAFE_BABE, 0, 5, 3, 16);
    check("spurious_injected", 32'(spur_fired), 32'd1);

    // Asynchronous reset during WAIT_DATA of word 1.
    push_word(0, 32'h1111_2222);
    push_word(1, 32'h3333_4444);
    valid_delay = 5;
    wait_left   = 0;
    wr_count    = 0;
    base_acc    = accepts;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (accepts < base_acc + 2 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("rst_word1_accepted", 32'(accepts - base_acc), 32'd2);
    @(negedge clk);
    @(negedge clk);
    check("rst_pre_wait_read", 32'(bus.flash_mem_read), 32'd0);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("midrun_rst");
    exp_wr_q.delete();
    exp_addr_q.delete();
    rd_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_word0_writes", 32'(wr_count), 32'd2);
    check("post_rst_idle_read", 32'(bus.flash_mem_read), 32'd0);
    check("post_rst_idle_done", 32'(done), 32'd0);

    // Rerun after reset, with sign-bit-heavy data passed through unchanged.
    do_run("rerun", 32'h8000_FFFF, 32'h7FFF_0000, 0, 1, -1, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
